tail_light_seq: RTL and testbench



---
 rtl/tail_light_pkg.sv | 17 +
 rtl/tail_light_prescaler.sv | 29 ++
 rtl/tail_light_seq.sv | 164 ++++++++++++++++
 tb/tb_tail_light_seq.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tail_light_pkg.sv
// Shared types and helpers for the tail-light sequencer: sequence state
// encoding and a per-bit thermometer decode.
package tail_light_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } tl_state_e;

    // Bit idx of a thermometer code of the given level is lit when idx < level.
    function automatic logic thermo_bit(input int idx, input int level);
        thermo_bit = (idx < level);
    endfunction

endpackage

// File: rtl/tail_light_prescaler.sv
// Step prescaler: counts 0..STEP_CYCLES-1 and raises tick in the last cycle
// of every step period.
module tail_light_prescaler #(
    parameter int STEP_CYCLES = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PW-1:0] LAST = PW'(STEP_CYCLES - 1);

    logic [PW-1:0] cnt_r;

    // Free-running step counter, wrapping at the end of each step period.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + PW'(1);
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/tail_light_seq.sv
// Thunderbird-style tail-light sequencer with hazard pre-emption and a step
// counter. Define TAIL_BRAKE_EN to add the brake port and brake overlay.
import tail_light_pkg::*;

module tail_light_seq #(
    parameter int LAMPS       = 3,
    parameter int STEP_CYCLES = 12_500_000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left,
    input  logic             right,
    input  logic             haz,
`ifdef TAIL_BRAKE_EN
    input  logic             brake,
`endif
    output logic [LAMPS-1:0] L,
    output logic [LAMPS-1:0] R,
    output logic [CNT_W-1:0] count
);

    localparam int PHW = $clog2(LAMPS + 1);
    localparam logic [PHW-1:0] PH_ONE  = PHW'(1);
    localparam logic [PHW-1:0] PH_LAST = PHW'(LAMPS);

    tl_state_e        state_r, state_next_s, disp_state_s;
    logic [PHW-1:0]   phase_r, phase_next_s, disp_phase_s;
    logic [LAMPS-1:0] sweep_s, lamp_l_s, lamp_r_s;
    logic             tick_s, haz_eff_s, brake_s;

    tail_light_prescaler #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

`ifdef TAIL_BRAKE_EN
    assign brake_s = brake;
`else
    assign brake_s = 1'b0;
`endif

    assign haz_eff_s = haz | (left & right);

    // Sequence selection made when idle or at the dark end of a sequence.
    always_comb begin
        if (haz_eff_s) begin
            disp_state_s = HAZ;
            disp_phase_s = PH_ONE;
        end else if (left) begin
            disp_state_s = LEFT;
            disp_phase_s = PH_ONE;
        end else if (right) begin
            disp_state_s = RIGHT;
            disp_phase_s = PH_ONE;
        end else begin
            disp_state_s = IDLE;
            disp_phase_s = '0;
        end
    end

    // Next state/phase; everything advances only on a prescaler tick.
    always_comb begin
        state_next_s = state_r;
        phase_next_s = phase_r;
        if (tick_s) begin
            case (state_r)
                LEFT, RIGHT: begin
                    if (haz_eff_s) begin
                        state_next_s = HAZ;
                        phase_next_s = PH_ONE;
                    end else if (phase_r == '0) begin
                        state_next_s = disp_state_s;
                        phase_next_s = disp_phase_s;
                    end else if (phase_r == PH_LAST) begin
                        phase_next_s = '0;
                    end else begin
                        phase_next_s = phase_r + PH_ONE;
                    end
                end
                HAZ: begin
                    if (phase_r == '0) begin
                        state_next_s = disp_state_s;
                        phase_next_s = disp_phase_s;
                    end else begin
                        phase_next_s = '0;
                    end
                end
                default: begin
                    state_next_s = disp_state_s;
                    phase_next_s = disp_phase_s;
                end
            endcase
        end else begin
            state_next_s = state_r;
            phase_next_s = phase_r;
        end
    end

    // Lamp pattern for the upcoming state; brake lights any non-sweeping side.
    always_comb begin
        sweep_s  = '0;
        lamp_l_s = '0;
        lamp_r_s = '0;
        for (int i = 0; i < LAMPS; i++) begin
            sweep_s[i] = thermo_bit(i, int'(phase_next_s));
        end
        case (state_next_s)
            LEFT:    lamp_l_s = sweep_s;
            RIGHT:   lamp_r_s = sweep_s;
            HAZ: begin
                if (phase_next_s != '0) begin
                    lamp_l_s = '1;
                    lamp_r_s = '1;
                end else begin
                    lamp_l_s = '0;
                    lamp_r_s = '0;
                end
            end
            default: begin
                lamp_l_s = '0;
                lamp_r_s = '0;
            end
        endcase
        if (brake_s && (state_next_s != HAZ)) begin
            if (state_next_s != LEFT) begin
                lamp_l_s = '1;
            end else begin
                lamp_l_s = lamp_l_s;
            end
            if (state_next_s != RIGHT) begin
                lamp_r_s = '1;
            end else begin
                lamp_r_s = lamp_r_s;
            end
        end else begin
            lamp_l_s = lamp_l_s;
            lamp_r_s = lamp_r_s;
        end
    end

    // State, phase, registered lamp outputs and the completed-step counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            phase_r <= '0;
            L       <= '0;
            R       <= '0;
            count   <= '0;
        end else begin
            state_r <= state_next_s;
            phase_r <= phase_next_s;
            L       <= lamp_l_s;
            R       <= lamp_r_s;
            if (tick_s && (state_r != IDLE)) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tail_light_seq.sv
// Self-checking bench for tail_light_seq: a frame-queue reference model is
// stepped alongside the DUT under directed and randomized switch stimulus.
module tb_tail_light_seq;

    localparam int LAMPS = 3;
    localparam int STEP  = 2;
    localparam int CNT_W = 8;
`ifdef TAIL_BRAKE_EN
    localparam bit HAS_BRAKE = 1'b1;
`else
    localparam bit HAS_BRAKE = 1'b0;
`endif
    localparam int K_IDLE = 0, K_LEFT = 1, K_RIGHT = 2, K_HAZ = 3;
    localparam logic [LAMPS-1:0] ALL = '1;

    logic clk = 1'b0;
    logic reset, left, right, haz, brake;
    logic [LAMPS-1:0] l_out, r_out;
    logic [CNT_W-1:0] cnt_out;

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of upcoming {L,R} frames per sequence.
    int ps = 0;
    int m_kind = K_IDLE;
    int m_cnt = 0;
    logic [2*LAMPS-1:0] m_cur = '0;
    logic [2*LAMPS-1:0] m_q[$];
    logic [LAMPS-1:0] exp_l = '0, exp_r = '0;
    logic [CNT_W-1:0] exp_cnt = '0;

    always #5 clk = ~clk;

    tail_light_seq #(
        .LAMPS       (LAMPS),
        .STEP_CYCLES (STEP),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .left  (left),
        .right (right),
        .haz   (haz),
`ifdef TAIL_BRAKE_EN
        .brake (brake),
`endif
        .L     (l_out),
        .R     (r_out),
        .count (cnt_out)
    );

    task automatic load_seq(input int k);
        logic [LAMPS-1:0] th;
        m_kind = k;
        m_q.delete();
        if (k == K_HAZ) begin
            m_q.push_back({ALL, ALL});
            m_q.push_back('0);
        end else begin
            for (int p = 1; p <= LAMPS; p++) begin
                th = LAMPS'((1 << p) - 1);
                if (k == K_LEFT) m_q.push_back({th, {LAMPS{1'b0}}});
                else             m_q.push_back({{LAMPS{1'b0}}, th});
            end
            m_q.push_back('0);
        end
        m_cur = m_q.pop_front();
    endtask

    task automatic model_edge();
        logic hz;
        if (reset) begin
            ps = 0; m_kind = K_IDLE; m_q.delete(); m_cur = '0; m_cnt = 0;
            exp_l = '0; exp_r = '0;
        end else begin
            if (ps == STEP - 1) begin
                if (m_kind != K_IDLE) m_cnt = (m_cnt + 1) % (1 << CNT_W);
                hz = haz | (left & right);
                if ((m_kind == K_LEFT || m_kind == K_RIGHT) && hz) load_seq(K_HAZ);
                else if (m_q.size() > 0) m_cur = m_q.pop_front();
                else if (hz)    load_seq(K_HAZ);
                else if (left)  load_seq(K_LEFT);
                else if (right) load_seq(K_RIGHT);
                else begin m_kind = K_IDLE; m_cur = '0; end
            end
            ps = (ps + 1) % STEP;
            exp_l = m_cur[2*LAMPS-1:LAMPS];
            exp_r = m_cur[LAMPS-1:0];
            if (HAS_BRAKE && brake && m_kind != K_HAZ) begin
                if (m_kind != K_LEFT)  exp_l = ALL;
                if (m_kind != K_RIGHT) exp_r = ALL;
            end
        end
        exp_cnt = CNT_W'(m_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; left = 1'b0; right = 1'b0; haz = 1'b0; brake = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; left = 1'b1; right = 1'b0; haz = 1'b0; brake = 1'b0;
        step(); step();
        checks++;
        if ({l_out, r_out, cnt_out} !== {3'b000, 3'b000, 8'd0}) begin
            errors++;
            $display("FAIL reset: L=%b R=%b count=%0d, want 000 000 0", l_out, r_out, cnt_out);
        end
        reset = 1'b0;
    endtask

    task automatic test_left_hold();
        do_reset();
        left = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if ({l_out, r_out, cnt_out} !== {exp_l, exp_r, exp_cnt}) begin
                errors++;
                $display("FAIL left_hold c%0d: L=%b R=%b count=%0d, want L=%b R=%b count=%0d",
                         i, l_out, r_out, cnt_out, exp_l, exp_r, exp_cnt);
            end
        end
    endtask

    task automatic test_right_pulse();
        do_reset();
        right = 1'b1;
        step(); step();
        right = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            checks++;
            if ({l_out, r_out, cnt_out} !== {exp_l, exp_r, exp_cnt}) begin
                errors++;
                $display("FAIL right_pulse c%0d: L=%b R=%b count=%0d, want L=%b R=%b count=%0d",
                         i, l_out, r_out, cnt_out, exp_l, exp_r, exp_cnt);
            end
        end
        checks++;
        if ({r_out, cnt_out} !== {3'b000, 8'd4}) begin
            errors++;
            $display("FAIL right_pulse_end: R=%b count=%0d, want 000 4", r_out, cnt_out);
        end
    endtask

    task automatic test_both();
        do_reset();
        left = 1'b1; right = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if ({l_out, r_out, cnt_out} !== {exp_l, exp_r, exp_cnt}) begin
                errors++;
                $display("FAIL both c%0d: L=%b R=%b count=%0d, want L=%b R=%b count=%0d",
                         i, l_out, r_out, cnt_out, exp_l, exp_r, exp_cnt);
            end
        end
        left = 1'b0; right = 1'b0;
    endtask

    task automatic test_haz_preempt();
        int n;
        do_reset();
        left = 1'b1;
        n = 0;
        while (exp_l != 3'b011 && n < 20) begin step(); n++; end
        checks++;
        if (l_out !== 3'b011) begin
            errors++;
            $display("FAIL haz_wait: L=%b, want 011 within 20 cycles", l_out);
        end
        haz = 1'b1;
        step(); step();
        checks++;
        if ({l_out, r_out} !== {3'b111, 3'b111}) begin
            errors++;
            $display("FAIL haz_preempt: L=%b R=%b, want 111 111", l_out, r_out);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({l_out, r_out, cnt_out} !== {exp_l, exp_r, exp_cnt}) begin
                errors++;
                $display("FAIL haz_run c%0d: L=%b R=%b count=%0d, want L=%b R=%b count=%0d",
                         i, l_out, r_out, cnt_out, exp_l, exp_r, exp_cnt);
            end
        end
        haz = 1'b0; left = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        left = 1'b1;
        n = 0;
        while (!(exp_l == 3'b011 && m_cnt == 5) && n < 40) begin step(); n++; end
        checks++;
        if ({l_out, cnt_out} !== {3'b011, 8'd5}) begin
            errors++;
            $display("FAIL reset_mid_wait: L=%b count=%0d, want 011 5", l_out, cnt_out);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({l_out, r_out, cnt_out} !== {3'b000, 3'b000, 8'd0}) begin
            errors++;
            $display("FAIL reset_mid: L=%b R=%b count=%0d, want 000 000 0", l_out, r_out, cnt_out);
        end
        step();
        step();
        checks++;
        if (l_out !== 3'b001) begin
            errors++;
            $display("FAIL reset_mid_restart: L=%b, want 001", l_out);
        end
        left = 1'b0;
    endtask

    task automatic test_brake();
        do_reset();
        left = 1'b1;
        for (int i = 0; i < 5; i++) step();
        brake = 1'b1;
        step();
        checks++;
        if (r_out !== 3'b111 || l_out !== exp_l) begin
            errors++;
            $display("FAIL brake_on: L=%b R=%b, want L=%b R=111", l_out, r_out, exp_l);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({l_out, r_out, cnt_out} !== {exp_l, exp_r, exp_cnt}) begin
                errors++;
                $display("FAIL brake_run c%0d: L=%b R=%b count=%0d, want L=%b R=%b count=%0d",
                         i, l_out, r_out, cnt_out, exp_l, exp_r, exp_cnt);
            end
        end
        brake = 1'b0;
        step();
        checks++;
        if (r_out !== 3'b000) begin
            errors++;
            $display("FAIL brake_off: R=%b, want 000", r_out);
        end
        left = 1'b0;
    endtask

    task automatic test_count_wrap();
        logic [CNT_W-1:0] prev;
        logic saw_wrap;
        do_reset();
        left = 1'b1;
        prev = '0;
        saw_wrap = 1'b0;
        for (int i = 0; i < 2 * 262; i++) begin
            step();
            checks++;
            if ({l_out, r_out, cnt_out} !== {exp_l, exp_r, exp_cnt}) begin
                errors++;
                $display("FAIL count_wrap c%0d: L=%b R=%b count=%0d, want L=%b R=%b count=%0d",
                         i, l_out, r_out, cnt_out, exp_l, exp_r, exp_cnt);
            end
            if (prev == 8'd255 && cnt_out == 8'd0) saw_wrap = 1'b1;
            prev = cnt_out;
        end
        checks++;
        if (saw_wrap !== 1'b1) begin
            errors++;
            $display("FAIL count_wrap_seen: wrap=%b, want 1", saw_wrap);
        end
        left = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) left  = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 7) == 0) right = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 9) == 0) haz   = ($urandom_range(0, 3) == 0);
            if (HAS_BRAKE && $urandom_range(0, 5) == 0) brake = ($urandom_range(0, 1) == 0);
            reset = ($urandom_range(0, 119) == 0);
            step();
            checks++;
            if ({l_out, r_out, cnt_out} !== {exp_l, exp_r, exp_cnt}) begin
                errors++;
                $display("FAIL random c%0d: L=%b R=%b count=%0d, want L=%b R=%b count=%0d",
                         i, l_out, r_out, cnt_out, exp_l, exp_r, exp_cnt);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; left = 1'b0; right = 1'b0; haz = 1'b0; brake = 1'b0;
        test_reset();
        test_left_hold();
        test_right_pulse();
        test_both();
        test_haz_preempt();
        test_reset_mid();
        if (HAS_BRAKE) test_brake();
        test_count_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
